// File: rtl/pixel_tick_pkg.sv
// Shared types, defaults and divisor clamp for the pixel tick generator.
package pixel_tick_pkg;

   localparam int unsigned CNT_W_DEF   = 8;
   localparam int unsigned DIV_RST_DEF = 4;
   localparam int unsigned CLAMP_W     = 32;

   typedef enum logic {
      IDLE_DIV = 1'b0,
      PEND_DIV = 1'b1
   } div_state_e;

   // A divisor of 0 or 1 both mean "tick every enabled cycle".
   function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] i_d);
      return (i_d < CLAMP_W'(2)) ? CLAMP_W'(1) : i_d;
   endfunction

endpackage

// File: rtl/pixel_tick_if.sv
// Control/status bundle between a pixel tick generator and its user.
interface pixel_tick_if
   import pixel_tick_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);

   logic             en;
   logic             sync;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic             div_ack;
   logic             tick;
   logic             half;
   logic [CNT_W-1:0] phase;
   logic [CNT_W-1:0] div_cur;

   modport master (
      output en, sync, div_in, div_load,
      input  div_ack, tick, half, phase, div_cur
   );

   modport slave (
      input  en, sync, div_in, div_load,
      output div_ack, tick, half, phase, div_cur
   );

endinterface

// File: rtl/pixel_tick_shadow.sv
// Divisor shadow register, pending FSM and apply-acknowledge pulse.
module pixel_tick_shadow
   import pixel_tick_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned DIV_RST = DIV_RST_DEF
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_div_load,
   input  logic [CNT_W-1:0] i_div_in,
   input  logic             i_boundary,
   output logic [CNT_W-1:0] o_div_cur,
   output logic             o_div_ack
);

   localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

   div_state_e       r_state;
   div_state_e       w_state_nxt;
   logic             w_apply;
   logic [CNT_W-1:0] w_div_clamped;
   logic [CNT_W-1:0] r_shadow;
   logic [CNT_W-1:0] r_div_cur;
   logic             r_div_ack;

   assign w_div_clamped = CNT_W'(clamp_div(CLAMP_W'(i_div_in)));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE_DIV;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A load on the boundary cycle refills the shadow, so pending survives.
   always_comb begin
      w_state_nxt = r_state;
      w_apply     = 1'b0;
      case (r_state)
         IDLE_DIV: begin
            if (i_div_load) begin
               w_state_nxt = PEND_DIV;
            end
         end
         PEND_DIV: begin
            w_apply = i_boundary;
            if (i_boundary && !i_div_load) begin
               w_state_nxt = IDLE_DIV;
            end
         end
         default: begin
            w_state_nxt = IDLE_DIV;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shadow <= DIV_RST_V;
      end else if (i_div_load) begin
         r_shadow <= w_div_clamped;
      end
   end

   // Apply uses the shadow as it stood before this cycle's load.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_div_cur <= DIV_RST_V;
         r_div_ack <= 1'b0;
      end else begin
         r_div_ack <= w_apply;
         if (w_apply) begin
            r_div_cur <= r_shadow;
         end
      end
   end

   assign o_div_cur = r_div_cur;
   assign o_div_ack = r_div_ack;

endmodule

// File: rtl/pixel_tick_gen.sv
// Programmable clock-enable generator: phase counter, tick/half decode, shadowed divisor.
module pixel_tick_gen
   import pixel_tick_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned DIV_RST = DIV_RST_DEF
) (
   input  logic        clk,
   input  logic        reset,
   pixel_tick_if.slave bus
);

   localparam int unsigned CW1 = CNT_W + 1;

   logic [CNT_W-1:0] r_phase;
   logic [CNT_W-1:0] w_div_cur;
   logic             w_last;
   logic             w_wrap;
   logic             w_boundary;
   logic [CNT_W:0]   w_half_lim;

   assign w_last     = (r_phase == (w_div_cur - CNT_W'(1)));
   assign w_wrap     = bus.en & w_last;
   assign w_boundary = bus.sync | w_wrap;

   // ceil(D/2) computed one bit wider so the maximum divisor cannot overflow.
   assign w_half_lim = ({1'b0, w_div_cur} + CW1'(1)) >> 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase <= '0;
      end else if (w_boundary) begin
         r_phase <= '0;
      end else if (bus.en) begin
         r_phase <= r_phase + CNT_W'(1);
      end
   end

   pixel_tick_shadow #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
   ) u_shadow (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_div_load (bus.div_load),
      .i_div_in   (bus.div_in),
      .i_boundary (w_boundary),
      .o_div_cur  (w_div_cur),
      .o_div_ack  (bus.div_ack)
   );

   assign bus.tick    = w_wrap & ~reset;
   assign bus.half    = ({1'b0, r_phase} < w_half_lim);
   assign bus.phase   = r_phase;
   assign bus.div_cur = w_div_cur;

endmodule

// File: doc/pixel_tick_gen.md
# pixel_tick_gen

Parametrised clock-enable generator; successor to the fixed divide-by-4 pixel clock. Produces a single-cycle `tick` every D enabled cycles of `clk`, with D programmable at run time via a shadow register that is only applied on a period boundary, so `tick` spacing never glitches. Also supplies phase count, a near-50% square output and a phase-align input for VGA/pixel timing and other rate-divided logic.

## Interface
- `CNT_W`, 8: width of counter and divisor.
- `DIV_RST`, 4: divisor after reset. Must satisfy 1 ≤ `DIV_RST` ≤ 2^`CNT_W`−1.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `en`  in  1  count enable; counter holds when low.
- `sync`  in  1  phase-align request, single-cycle pulse.
- `div_in`  in  `CNT_W`  new divisor value.
- `div_load`  in  1  capture `div_in` into shadow register.
- `div_ack`  out  1  one-cycle pulse: a new divisor took effect.
- `tick`  out  1  clock-enable pulse, last cycle of each period.
- `half`  out  1  square wave; high for first ceil(D/2) counts.
- `phase`  out  `CNT_W`  current count, 0..D−1.
- `div_cur`  out  `CNT_W`  divisor in use.

## Operation
- Divisor rule: `div_in` of 0 or 1 stored as 1. D=1 means `tick` = `en` every cycle, `phase` stays 0.
- Counter: if `en`, `phase` increments; at `phase` = D−1 it wraps to 0 ("wrap").
- `tick` = `en` & (`phase` == D−1) & !`reset`. Combinational from registers and `en`.
- `half` = (`phase` < ceil(D/2)). Registered-state decode, no `en` qualification.
- Shadow register: `div_load` writes the shadow and sets `pending`. A further load while pending overwrites (last wins).
- Apply: on a wrap cycle with `pending`=1, `div_cur`←shadow, `pending`←0, `phase`←0, and `div_ack` pulses the next cycle.
- A `div_load` in the same cycle as a wrap is captured but not applied. It is applied at the following wrap.
- `sync`: `phase`←0 regardless of `en`. If `pending`, the shadow is applied in the same cycle and `div_ack` pulses next cycle. `tick` is not forced by `sync`.
- Priority per cycle: `reset` > `sync` > wrap/apply > increment > hold. `div_load` capture is independent of all but `reset`.
- States (explicit two-state FSM): IDLE_DIV (`pending`=0), PEND_DIV (`pending`=1).
  - IDLE_DIV→PEND_DIV on `div_load`.
  - PEND_DIV→IDLE_DIV on wrap or `sync`, unless `div_load` is also asserted, in which case it stays in PEND_DIV.
- Mid-operation `reset`: discards the shadow. `div_cur`←`DIV_RST`, `phase`←0.

## Timing
- Reset values: `phase`=0, `div_cur`=`DIV_RST`, `pending`=0, `div_ack`=0, `tick`=0 (forced during reset), `half`=1.
- With `en`=1 continuously from the first cycle after reset, `tick` is high on cycles D−1, 2D−1, … (cycle 0 is the first post-reset cycle).
- `div_ack` latency: 1 cycle after the apply edge.
- The first period at a new divisor starts in the cycle after the applying wrap and lasts exactly new-D enabled cycles.
- `en` low freezes `phase`, `half` and any `pending` state. `tick` is low while `en` is low.

## Structure
- Shared package `pixel_tick_pkg`:
  - default `CNT_W` and `DIV_RST`;
  - the two-value enum for IDLE_DIV/PEND_DIV;
  - the divisor-clamp function (0/1 → 1).
- One natural sub-module: `pixel_tick_shadow`, containing the shadow register, `pending` FSM and `div_ack` register. The counter and decode live in the top module.

## Test plan
- Reset, then `en`=1 with `DIV_RST`=4 for 12 cycles → `tick` on cycles 3, 7, 11; `phase` 0,1,2,3 repeating; `half` high for `phase` 0–1.
- `div_load` with `div_in`=6 at `phase`=1 → `div_cur` stays 4 until the wrap at `phase`=3. Then `div_ack` pulses once, and the next `tick` comes 6 cycles after the wrap.
- `div_load` with `div_in`=0, then `div_load` with `div_in`=5 on the next cycle, both before a wrap → after the wrap `div_cur`=5 and a single `div_ack` pulse; `div_in`=0 alone → `div_cur`=1 and `tick`=`en` every cycle.
- `sync` at `phase`=2 with `pending`=0 → next `phase`=0, no `tick`, no `div_ack`. `sync` while pending (shadow 3) → `div_cur`=3 immediately and `div_ack` next cycle.
- Toggle `en` low for 5 cycles at `phase`=2 → `phase`, `half` and `pending` hold and `tick`=0; resuming continues at `phase`=3 with `tick` high.
- Assert `reset` while pending with `div_cur`=7 → `div_cur`=4, `phase`=0, `pending`=0, and no `div_ack` afterwards.
